// File: rtl/cache_ctrl_pkg.sv
// Shared definitions for the cache miss controller: FSM state encoding and
// the default memory latency.
package cache_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COMPARE   = 2'd1,
    WRITEBACK = 2'd2,
    ALLOCATE  = 2'd3
  } state_t;

  localparam int MEM_LAT_DEFAULT = 8;

endpackage

// File: rtl/cache_miss_ctrl_if.sv
// CPU / tag-array / memory-side signal bundle of the cache miss controller.
// The master side is the environment, the slave side is the controller.
interface cache_miss_ctrl_if;

  logic       cpu_req;
  logic       cpu_we;
  logic       hit;
  logic       dirty;
  logic       busy;
  logic       ready;
  logic       mem_write;
  logic       mem_read;
  logic       line_we;
  logic       word_we;
  logic [3:0] wait_cnt;

  modport master (
    output cpu_req, cpu_we, hit, dirty,
    input  busy, ready, mem_write, mem_read, line_we, word_we, wait_cnt
  );

  modport slave (
    input  cpu_req, cpu_we, hit, dirty,
    output busy, ready, mem_write, mem_read, line_we, word_we, wait_cnt
  );

endinterface

// File: rtl/latency_timer.sv
// 4-bit cycle counter used to time memory write-back and refill phases.
// Clear has priority over enable.
module latency_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_clear,
  input  logic       i_enable,
  output logic [3:0] o_count
);

  logic [3:0] r_count;

  always_ff @(posedge clk) begin
    if (reset || i_clear)
      r_count <= 4'd0;
    else if (i_enable)
      r_count <= r_count + 4'd1;
  end

  assign o_count = r_count;

endmodule

// File: rtl/cache_miss_ctrl.sv
// Cache miss controller: compares, writes back dirty victims and refills
// lines, each memory phase lasting exactly MEM_LAT cycles.
module cache_miss_ctrl
  import cache_ctrl_pkg::*;
#(
  parameter int MEM_LAT = MEM_LAT_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  cache_miss_ctrl_if.slave   bus
);

  localparam logic [3:0] LAST_CNT = 4'(MEM_LAT - 1);
  localparam logic [3:0] PRE_LAST = 4'(MEM_LAT - 2);

  state_t     r_state;
  logic       r_busy;
  logic       r_memRead;
  logic       r_memWrite;
  logic       r_lineWe;
  logic [3:0] w_cnt;
  logic       w_inMem;
  logic       w_lastCycle;
  logic       w_timerClear;
  logic       w_ready;

  assign w_inMem      = (r_state == WRITEBACK) || (r_state == ALLOCATE);
  assign w_lastCycle  = w_inMem && (w_cnt == LAST_CNT);
  assign w_timerClear = !w_inMem || w_lastCycle;

  latency_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (w_timerClear),
    .i_enable (w_inMem),
    .o_count  (w_cnt)
  );

  // Strobes are registered from the next state; line_we is set one cycle
  // early so it lands on the final refill cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_busy     <= 1'b0;
      r_memRead  <= 1'b0;
      r_memWrite <= 1'b0;
      r_lineWe   <= 1'b0;
    end else begin
      r_lineWe <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.cpu_req) begin
            r_state <= COMPARE;
            r_busy  <= 1'b1;
          end
        end
        COMPARE: begin
          if (bus.hit) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (bus.dirty) begin
            r_state    <= WRITEBACK;
            r_memWrite <= 1'b1;
          end else begin
            r_state   <= ALLOCATE;
            r_memRead <= 1'b1;
          end
        end
        WRITEBACK: begin
          if (w_lastCycle) begin
            r_state    <= ALLOCATE;
            r_memWrite <= 1'b0;
            r_memRead  <= 1'b1;
          end
        end
        ALLOCATE: begin
          if (w_lastCycle) begin
            r_state   <= COMPARE;
            r_memRead <= 1'b0;
          end else if (w_cnt == PRE_LAST) begin
            r_lineWe <= 1'b1;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_busy     <= 1'b0;
          r_memRead  <= 1'b0;
          r_memWrite <= 1'b0;
        end
      endcase
    end
  end

  // Outputs are forced low while reset is asserted, even before state settles.
  assign w_ready      = (r_state == COMPARE) && bus.hit && !reset;
  assign bus.ready    = w_ready;
  assign bus.word_we  = w_ready && bus.cpu_we;
  assign bus.busy     = r_busy && !reset;
  assign bus.mem_read = r_memRead && !reset;
  assign bus.mem_write = r_memWrite && !reset;
  assign bus.line_we  = r_lineWe && !reset;
  assign bus.wait_cnt = reset ? 4'd0 : w_cnt;

endmodule
